m_of_n_code_monitor: RTL and testbench

// Pipelined checker for M-out-of-N code words, generalising the fixed 2-of-5 detector.

---
 rtl/m_of_n_code_monitor.sv | 136 +++++++++++++
 tb/tb_m_of_n_code_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/m_of_n_code_monitor.sv
// Two-stage M-out-of-N code word checker with saturating statistics,
// sticky error flag and consecutive-error alarm.
module m_of_n_code_monitor #(
    parameter int N         = 5,
    parameter int M         = 2,
    parameter int CNT_W     = 16,
    parameter int BURST_LIM = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     code_valid_i,
    input  logic [N-1:0]             code_i,
    input  logic                     clr_i,
    output logic                     det_valid_o,
    output logic                     det_o,
    output logic [$clog2(N+1)-1:0]   ones_o,
    output logic [CNT_W-1:0]         word_cnt_o,
    output logic [CNT_W-1:0]         err_cnt_o,
    output logic                     err_sticky_o,
    output logic                     alarm_o
);

    localparam int OW = $clog2(N+1);
    localparam logic [OW-1:0]    M_C      = OW'(M);
    localparam logic [7:0]       LIM_C    = 8'(BURST_LIM);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       BC_MAX   = 8'hFF;

    if ((N < 2) || (N > 32)) begin : g_bad_n
        $error("m_of_n_code_monitor: N must lie in 2..32");
    end
    if ((M < 0) || (M > N)) begin : g_bad_m
        $error("m_of_n_code_monitor: M must lie in 0..N");
    end
    if ((BURST_LIM < 1) || (BURST_LIM > 255)) begin : g_bad_lim
        $error("m_of_n_code_monitor: BURST_LIM must lie in 1..255");
    end

    function automatic logic [OW-1:0] popcount(input logic [N-1:0] w);
        logic [OW-1:0] c;
        c = {OW{1'b0}};
        for (int i = 0; i < N; i++) begin
            c = c + {{(OW-1){1'b0}}, w[i]};
        end
        return c;
    endfunction

    logic              v1_q,        v1_d;
    logic [OW-1:0]     ones1_q,     ones1_d;
    logic              det_valid_q, det_valid_d;
    logic              det_q,       det_d;
    logic [OW-1:0]     ones_q,      ones_d;
    logic [CNT_W-1:0]  word_cnt_q,  word_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q,   err_cnt_d;
    logic              sticky_q,    sticky_d;
    logic              alarm_q,     alarm_d;
    logic [7:0]        bc_q,        bc_d;
    logic              err_s;
    logic [7:0]        bc_next_s;

    // Next-state logic for both pipeline stages, statistics and burst tracking
    always_comb begin
        v1_d        = code_valid_i;
        ones1_d     = popcount(code_i);
        det_valid_d = v1_q;
        err_s       = v1_q && (ones1_q != M_C);

        if (v1_q) begin
            det_d  = (ones1_q != M_C);
            ones_d = ones1_q;
        end else begin
            det_d  = det_q;
            ones_d = ones_q;
        end

        // Idle cycles leave the burst count untouched; a good word breaks the run.
        if (err_s) begin
            bc_next_s = (bc_q == BC_MAX) ? BC_MAX : (bc_q + 8'd1);
        end else if (v1_q) begin
            bc_next_s = 8'd0;
        end else begin
            bc_next_s = bc_q;
        end

        if (clr_i) begin
            word_cnt_d = {CNT_W{1'b0}};
            err_cnt_d  = {CNT_W{1'b0}};
            sticky_d   = 1'b0;
            alarm_d    = 1'b0;
            bc_d       = 8'd0;
        end else begin
            word_cnt_d = (v1_q && (word_cnt_q != CNT_MAX)) ? (word_cnt_q + CNT_ONE) : word_cnt_q;
            err_cnt_d  = (err_s && (err_cnt_q != CNT_MAX)) ? (err_cnt_q + CNT_ONE) : err_cnt_q;
            sticky_d   = sticky_q | err_s;
            alarm_d    = alarm_q | (bc_next_s >= LIM_C);
            bc_d       = bc_next_s;
        end
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q        <= 1'b0;
            ones1_q     <= {OW{1'b0}};
            det_valid_q <= 1'b0;
            det_q       <= 1'b0;
            ones_q      <= {OW{1'b0}};
            word_cnt_q  <= {CNT_W{1'b0}};
            err_cnt_q   <= {CNT_W{1'b0}};
            sticky_q    <= 1'b0;
            alarm_q     <= 1'b0;
            bc_q        <= 8'd0;
        end else begin
            v1_q        <= v1_d;
            ones1_q     <= ones1_d;
            det_valid_q <= det_valid_d;
            det_q       <= det_d;
            ones_q      <= ones_d;
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
            sticky_q    <= sticky_d;
            alarm_q     <= alarm_d;
            bc_q        <= bc_d;
        end
    end

    assign det_valid_o  = det_valid_q;
    assign det_o        = det_q;
    assign ones_o       = ones_q;
    assign word_cnt_o   = word_cnt_q;
    assign err_cnt_o    = err_cnt_q;
    assign err_sticky_o = sticky_q;
    assign alarm_o      = alarm_q;

endmodule

// File: tb/tb_m_of_n_code_monitor.sv
// Bench for m_of_n_code_monitor: directed scenarios plus random traffic,
// two instances (wide and 4-bit counters) checked against a queue-based model.
module tb_m_of_n_code_monitor;

    localparam int N = 5;
    localparam int M = 2;
    localparam int LIM = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cv = 1'b0;
    logic [N-1:0] code = '0;
    logic clr = 1'b0;

    logic dv_a, det_a, st_a, al_a;
    logic [2:0] ones_a;
    logic [15:0] wc_a, ec_a;
    logic dv_b, det_b, st_b, al_b;
    logic [2:0] ones_b;
    logic [3:0] wc_b, ec_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m_of_n_code_monitor #(.N(N), .M(M), .CNT_W(16), .BURST_LIM(LIM)) dut_a (
        .clk_i(clk), .rst_i(rst), .code_valid_i(cv), .code_i(code), .clr_i(clr),
        .det_valid_o(dv_a), .det_o(det_a), .ones_o(ones_a), .word_cnt_o(wc_a),
        .err_cnt_o(ec_a), .err_sticky_o(st_a), .alarm_o(al_a));

    m_of_n_code_monitor #(.N(N), .M(M), .CNT_W(4), .BURST_LIM(LIM)) dut_b (
        .clk_i(clk), .rst_i(rst), .code_valid_i(cv), .code_i(code), .clr_i(clr),
        .det_valid_o(dv_b), .det_o(det_b), .ones_o(ones_b), .word_cnt_o(wc_b),
        .err_cnt_o(ec_b), .err_sticky_o(st_b), .alarm_o(al_b));

    // Model state: words in flight with the edge they complete on, plus
    // unsaturated totals since the last clear.
    typedef struct { int due; logic [N-1:0] w; } word_t;
    word_t pend[$];
    int cyc = 0;
    bit model_ok = 1'b0;
    int e_dv, e_det, e_ones, wtot, etot, burst, e_alarm, e_sticky;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step(input bit v, input logic [N-1:0] c, input bit cl, input bit r);
        word_t wd;
        cyc++;
        if (r) begin
            pend.delete();
            e_dv = 0; e_det = 0; e_ones = 0; wtot = 0; etot = 0;
            burst = 0; e_alarm = 0; e_sticky = 0;
            model_ok = 1'b1;
        end else begin
            e_dv = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                wd = pend.pop_front();
                e_dv = 1;
                e_ones = $countones(wd.w);
                e_det = (e_ones != M) ? 1 : 0;
                wtot++;
                if (e_det == 1) begin
                    etot++;
                    burst = (burst < 255) ? burst + 1 : 255;
                    e_sticky = 1;
                end else begin
                    burst = 0;
                end
                if (burst >= LIM) e_alarm = 1;
            end
            if (cl) begin
                wtot = 0; etot = 0; burst = 0; e_alarm = 0; e_sticky = 0;
            end
            if (v) pend.push_back('{cyc + 1, c});
        end
    endtask

    task automatic step(input bit v, input logic [N-1:0] c, input bit cl, input bit r);
        @(negedge clk);
        cv = v; code = c; clr = cl; rst = r;
        @(posedge clk);
        model_step(v, c, cl, r);
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (model_ok) begin
            chk("a_det_valid", 32'(dv_a), 32'(e_dv));
            chk("a_det", 32'(det_a), 32'(e_det));
            chk("a_ones", 32'(ones_a), 32'(e_ones));
            chk("a_word_cnt", 32'(wc_a), 32'(sat(wtot, 16)));
            chk("a_err_cnt", 32'(ec_a), 32'(sat(etot, 16)));
            chk("a_sticky", 32'(st_a), 32'(e_sticky));
            chk("a_alarm", 32'(al_a), 32'(e_alarm));
            chk("b_det_valid", 32'(dv_b), 32'(e_dv));
            chk("b_det", 32'(det_b), 32'(e_det));
            chk("b_ones", 32'(ones_b), 32'(e_ones));
            chk("b_word_cnt", 32'(wc_b), 32'(sat(wtot, 4)));
            chk("b_err_cnt", 32'(ec_b), 32'(sat(etot, 4)));
            chk("b_sticky", 32'(st_b), 32'(e_sticky));
            chk("b_alarm", 32'(al_b), 32'(e_alarm));
        end
    end

    initial begin
        logic [N-1:0] err_w;
        err_w = 5'b00111;

        // Reset, then idle
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("rst_outputs", {dv_a, det_a, st_a, al_a, 1'b0, ones_a, wc_a, 4'h0, ec_a[3:0]}, 32'h0);
        chk("rst_err_cnt", 32'(ec_a), 32'h0);

        // Single good word then single bad word
        step(1'b1, 5'b00011, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("t2_good", {29'h0, dv_a, det_a, 1'b0}, {29'h0, 1'b1, 1'b0, 1'b0});
        chk("t2_good_ones", 32'(ones_a), 32'd2);
        step(1'b1, err_w, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("t2_bad_det", 32'(det_a), 32'd1);
        chk("t2_bad_ones", 32'(ones_a), 32'd3);
        chk("t2_err_cnt", 32'(ec_a), 32'd1);
        chk("t2_sticky", 32'(st_a), 32'd1);

        // All 32 codes back-to-back
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) step(1'b1, 5'(i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("t3_word_cnt", 32'(wc_a), 32'd32);
        chk("t3_err_cnt", 32'(ec_a), 32'd22);
        chk("t3_alarm", 32'(al_a), 32'd1);

        // Interrupted burst does not alarm; third consecutive error does
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, err_w, 1'b0, 1'b0);
        step(1'b1, err_w, 1'b0, 1'b0);
        step(1'b1, 5'b10100, 1'b0, 1'b0);
        step(1'b1, err_w, 1'b0, 1'b0);
        step(1'b1, err_w, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("t4_no_alarm", 32'(al_a), 32'd0);
        step(1'b1, 5'b11111, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("t4_alarm", {30'h0, dv_a, al_a}, {30'h0, 1'b1, 1'b1});

        // Saturation of 4-bit counters, then CLR on a completing word
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, err_w, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("t5_b_err_sat", 32'(ec_b), 32'd15);
        chk("t5_a_err", 32'(ec_a), 32'd20);
        step(1'b1, err_w, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        #1;
        chk("t5_clr_dv", {30'h0, dv_b, det_b}, {30'h0, 1'b1, 1'b1});
        chk("t5_clr_cnts", {24'h0, wc_b, ec_b}, 32'h0);
        chk("t5_clr_flags", {30'h0, st_b, al_b}, 32'h0);

        // Reset while a word is in flight
        step(1'b1, 5'b00011, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        #1;
        chk("t6_rst_dv", 32'(dv_a), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("t6_no_dv", 32'(dv_a), 32'd0);
        chk("t6_cnts", {wc_a, ec_a}, 32'h0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) < 75, 5'($urandom()),
                 $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
